// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bundle: pipeline hazard inputs and stall/flush/freeze outputs.
// stall_count exists only when HAZARD_STATS_EN is defined.
interface hazard_sequencer_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             forward_en;
    logic             branch_taken;
    logic             mem_access;
    logic             sram_ready;
    logic             freeze_pc;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             freeze_all;
    logic [1:0]       state;
    logic             mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count;
`endif

    if (REG_W < 1 || CNT_W < 1) begin : g_param_check
        $error("hazard_sequencer_if: widths must be positive");
    end

    modport master (
        output src1, src2, two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en,
        output mem_dest, mem_wb_en,
        output forward_en, branch_taken,
        output mem_access, sram_ready,
        input  freeze_pc, flush_if_id,
        input  flush_id_ex, freeze_all,
        input  state, mem_timeout
`ifdef HAZARD_STATS_EN
        , input stall_count
`endif
    );

    modport slave (
        input  src1, src2, two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en,
        input  mem_dest, mem_wb_en,
        input  forward_en, branch_taken,
        input  mem_access, sram_ready,
        output freeze_pc, flush_if_id,
        output flush_id_ex, freeze_all,
        output state, mem_timeout
`ifdef HAZARD_STATS_EN
        , output stall_count
`endif
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline (RUN/STALL/WAIT/FLUSH).
// Optional stall statistics counter enabled by HAZARD_STATS_EN.
module hazard_sequencer #(
    parameter int REG_W      = 4,
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    hazard_sequencer_if.slave hs
);
    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_STALL = 2'b01,
        S_WAIT  = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    localparam int WCW = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCW-1:0] LIM    = WCW'(WAIT_LIMIT);
    localparam logic [WCW-1:0] LIM_M1 = WCW'(WAIT_LIMIT - 1);

    if (REG_W < 1 || CNT_W < 1 || WAIT_LIMIT < 1) begin : g_param_check
        $error("hazard_sequencer: parameters must be positive");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WCW-1:0]   r_wcnt;
    logic             r_timeout;
    logic [REG_W-1:0] w_src1;
    logic [REG_W-1:0] w_src2;
    logic [REG_W-1:0] w_exe_dest;
    logic [REG_W-1:0] w_mem_dest;
    logic             w_raw_exe;
    logic             w_raw_mem;
    logic             w_hz_raw;
    logic             w_hazard;
    logic             w_wait;
    logic             w_br;
    logic             w_freeze_pc;
    logic             w_flush_if_id;
    logic             w_flush_id_ex;
    logic             w_freeze_all;

    assign w_src1     = hs.src1;
    assign w_src2     = hs.src2;
    assign w_exe_dest = hs.exe_dest;
    assign w_mem_dest = hs.mem_dest;
    assign w_br       = hs.branch_taken;

    assign w_raw_exe = hs.exe_wb_en &&
        (w_exe_dest == w_src1 ||
         (hs.two_src && w_exe_dest == w_src2));
    assign w_raw_mem = hs.mem_wb_en &&
        (w_mem_dest == w_src1 ||
         (hs.two_src && w_mem_dest == w_src2));
    assign w_hz_raw = hs.forward_en ?
        (w_raw_exe && hs.exe_mem_r_en) :
        (w_raw_exe || w_raw_mem);

    // ID holds the bubble we just inserted, so its sources are meaningless
    assign w_hazard = w_hz_raw && (r_state != S_FLUSH);

    // Once in WAIT the pipeline stays held until SRAM reports completion
    assign w_wait = (r_state == S_WAIT) ? !hs.sram_ready :
                    (hs.mem_access && !hs.sram_ready);

    assign w_freeze_all  = w_wait;
    assign w_freeze_pc   = w_wait || (w_hazard && !w_br);
    assign w_flush_if_id = w_br && !w_wait;
    assign w_flush_id_ex = (w_hazard || w_br) && !w_wait;

    always_comb begin
        w_next = S_RUN;
        unique case (r_state)
            S_FLUSH: begin
                w_next = w_wait ? S_WAIT : S_RUN;
            end
            default: begin
                if (w_wait)
                    w_next = S_WAIT;
                else if (w_br)
                    w_next = S_FLUSH;
                else if (w_hazard)
                    w_next = S_STALL;
                else
                    w_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= S_RUN;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_wait)
                r_wcnt <= '0;
            else if (r_wcnt != LIM)
                r_wcnt <= r_wcnt + 1'b1;
            if (w_wait && r_wcnt == LIM_M1)
                r_timeout <= 1'b1;
        end
    end

    assign hs.freeze_pc   = w_freeze_pc && i_rst;
    assign hs.flush_if_id = w_flush_if_id && i_rst;
    assign hs.flush_id_ex = w_flush_id_ex && i_rst;
    assign hs.freeze_all  = w_freeze_all && i_rst;
    assign hs.state       = r_state;
    assign hs.mem_timeout = r_timeout;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_stall_cnt <= '0;
        else if ((w_freeze_pc || w_freeze_all) && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign hs.stall_count = r_stall_cnt;
`else
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer (WAIT_LIMIT=8).
// Output vector order: {freeze_pc, flush_if_id, flush_id_ex, freeze_all}.
module tb_hazard_sequencer;
    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    hazard_sequencer_if #(.REG_W(4), .CNT_W(16)) hif ();

    hazard_sequencer #(
        .REG_W(4),
        .WAIT_LIMIT(8),
        .CNT_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .hs(hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] outs();
        return {hif.freeze_pc, hif.flush_if_id,
                hif.flush_id_ex, hif.freeze_all};
    endfunction

    task automatic clear_inputs();
        hif.src1 = 4'd1;
        hif.src2 = 4'd2;
        hif.two_src = 1'b0;
        hif.exe_dest = 4'd9;
        hif.exe_wb_en = 1'b0;
        hif.exe_mem_r_en = 1'b0;
        hif.mem_dest = 4'd10;
        hif.mem_wb_en = 1'b0;
        hif.forward_en = 1'b1;
        hif.branch_taken = 1'b0;
        hif.mem_access = 1'b0;
        hif.sram_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        hif.forward_en = 1'b1;
        hif.exe_mem_r_en = 1'b1;
        hif.exe_wb_en = 1'b1;
        hif.exe_dest = 4'd3;
        hif.src1 = 4'd3;
        hif.branch_taken = 1'b1;
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        #2;
        vecs++;
        if (outs() !== 4'b0000) begin
            $display("FAIL reset_outs: got %b want 0000", outs());
            errs++;
        end
        vecs++;
        if (hif.state !== 2'b00 || hif.mem_timeout !== 1'b0) begin
            $display("FAIL reset_state: got st=%b to=%b want 00/0",
                     hif.state, hif.mem_timeout);
            errs++;
        end
`ifdef HAZARD_STATS_EN
        vecs++;
        if (hif.stall_count !== 16'd0) begin
            $display("FAIL reset_cnt: got %0d want 0", hif.stall_count);
            errs++;
        end
`endif
        clear_inputs();
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        hif.forward_en = 1'b1;
        hif.exe_mem_r_en = 1'b1;
        hif.exe_wb_en = 1'b1;
        hif.exe_dest = 4'd3;
        hif.src1 = 4'd3;
        #2;
        vecs++;
        if (outs() !== 4'b1010) begin
            $display("FAIL load_use_outs: got %b want 1010", outs());
            errs++;
        end
        tick();
        clear_inputs();
        #1;
        vecs++;
        if (hif.state !== 2'b01 || outs() !== 4'b0000) begin
            $display("FAIL load_use_stall: got st=%b o=%b want 01/0000",
                     hif.state, outs());
            errs++;
        end
        tick();
        vecs++;
        if (hif.state !== 2'b00) begin
            $display("FAIL load_use_run: got %b want 00", hif.state);
            errs++;
        end
    endtask

    task automatic test_no_forward();
        hif.forward_en = 1'b0;
        hif.mem_wb_en = 1'b1;
        hif.mem_dest = 4'd5;
        hif.src2 = 4'd5;
        hif.two_src = 1'b1;
        #2;
        vecs++;
        if (outs() !== 4'b1010) begin
            $display("FAIL nofwd_outs: got %b want 1010", outs());
            errs++;
        end
        tick();
        vecs++;
        if (hif.state !== 2'b01 || outs() !== 4'b1010) begin
            $display("FAIL nofwd_held: got st=%b o=%b want 01/1010",
                     hif.state, outs());
            errs++;
        end
        tick();
        hif.two_src = 1'b0;
        #1;
        vecs++;
        if (hif.state !== 2'b01 || outs() !== 4'b0000) begin
            $display("FAIL nofwd_one_src: got st=%b o=%b want 01/0000",
                     hif.state, outs());
            errs++;
        end
        tick();
        vecs++;
        if (hif.state !== 2'b00) begin
            $display("FAIL nofwd_release: got %b want 00", hif.state);
            errs++;
        end
        clear_inputs();
    endtask

    task automatic test_no_hazard_cases();
        hif.forward_en = 1'b1;
        hif.exe_wb_en = 1'b1;
        hif.exe_dest = 4'd3;
        hif.src1 = 4'd3;
        hif.exe_mem_r_en = 1'b0;
        #1;
        vecs++;
        if (outs() !== 4'b0000) begin
            $display("FAIL fwd_alu_result: got %b want 0000", outs());
            errs++;
        end
        hif.forward_en = 1'b0;
        hif.exe_wb_en = 1'b0;
        hif.exe_dest = 4'd0;
        hif.src1 = 4'd0;
        #1;
        vecs++;
        if (outs() !== 4'b0000) begin
            $display("FAIL no_wb_en: got %b want 0000", outs());
            errs++;
        end
        hif.exe_wb_en = 1'b1;
        #1;
        vecs++;
        if (outs() !== 4'b1010) begin
            $display("FAIL reg0_raw: got %b want 1010", outs());
            errs++;
        end
        clear_inputs();
        tick();
        vecs++;
        if (hif.state !== 2'b00) begin
            $display("FAIL no_hazard_state: got %b want 00", hif.state);
            errs++;
        end
    endtask

    task automatic test_branch_hazard();
        hif.forward_en = 1'b1;
        hif.exe_mem_r_en = 1'b1;
        hif.exe_wb_en = 1'b1;
        hif.exe_dest = 4'd7;
        hif.src1 = 4'd7;
        hif.branch_taken = 1'b1;
        #2;
        vecs++;
        if (outs() !== 4'b0110) begin
            $display("FAIL br_hz_outs: got %b want 0110", outs());
            errs++;
        end
        tick();
        hif.branch_taken = 1'b0;
        #1;
        vecs++;
        if (hif.state !== 2'b11 || outs() !== 4'b0000) begin
            $display("FAIL br_flush: got st=%b o=%b want 11/0000",
                     hif.state, outs());
            errs++;
        end
        tick();
        clear_inputs();
        vecs++;
        if (hif.state !== 2'b00) begin
            $display("FAIL br_after_flush: got %b want 00", hif.state);
            errs++;
        end
    endtask

    task automatic test_sram_wait();
        do_reset();
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (outs() !== 4'b1001 ||
                hif.state !== ((i == 0) ? 2'b00 : 2'b10)) begin
                $display("FAIL sram_wait_%0d: got o=%b st=%b", i,
                         outs(), hif.state);
                errs++;
            end
            tick();
        end
        hif.sram_ready = 1'b1;
        #1;
        vecs++;
        if (outs() !== 4'b0000 || hif.state !== 2'b10) begin
            $display("FAIL sram_ready: got o=%b st=%b want 0000/10",
                     outs(), hif.state);
            errs++;
        end
        tick();
        clear_inputs();
        vecs++;
        if (hif.state !== 2'b00) begin
            $display("FAIL sram_exit: got %b want 00", hif.state);
            errs++;
        end
`ifdef HAZARD_STATS_EN
        vecs++;
        if (hif.stall_count !== 16'd4) begin
            $display("FAIL stall_count: got %0d want 4", hif.stall_count);
            errs++;
        end
`endif
    endtask

    task automatic test_wait_branch();
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        hif.branch_taken = 1'b1;
        #1;
        vecs++;
        if (outs() !== 4'b1001) begin
            $display("FAIL wait_br_hold: got %b want 1001", outs());
            errs++;
        end
        tick();
        vecs++;
        if (hif.state !== 2'b10 || outs() !== 4'b1001) begin
            $display("FAIL wait_br_in_wait: got st=%b o=%b want 10/1001",
                     hif.state, outs());
            errs++;
        end
        hif.sram_ready = 1'b1;
        #1;
        vecs++;
        if (outs() !== 4'b0110) begin
            $display("FAIL wait_br_ready: got %b want 0110", outs());
            errs++;
        end
        tick();
        clear_inputs();
        vecs++;
        if (hif.state !== 2'b11) begin
            $display("FAIL wait_br_flush: got %b want 11", hif.state);
            errs++;
        end
        tick();
    endtask

    task automatic test_flush_wait();
        hif.branch_taken = 1'b1;
        tick();
        hif.branch_taken = 1'b0;
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        #1;
        vecs++;
        if (hif.state !== 2'b11 || outs() !== 4'b1001) begin
            $display("FAIL flush_wait: got st=%b o=%b want 11/1001",
                     hif.state, outs());
            errs++;
        end
        tick();
        vecs++;
        if (hif.state !== 2'b10) begin
            $display("FAIL flush_to_wait: got %b want 10", hif.state);
            errs++;
        end
        hif.sram_ready = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7) begin
                vecs++;
                if (hif.mem_timeout !== 1'b0) begin
                    $display("FAIL timeout_early: got %b want 0",
                             hif.mem_timeout);
                    errs++;
                end
            end
            if (k == 8) begin
                vecs++;
                if (hif.mem_timeout !== 1'b1) begin
                    $display("FAIL timeout_set: got %b want 1",
                             hif.mem_timeout);
                    errs++;
                end
            end
        end
        vecs++;
        if (hif.state !== 2'b10) begin
            $display("FAIL timeout_in_wait: got %b want 10", hif.state);
            errs++;
        end
        hif.sram_ready = 1'b1;
        tick();
        clear_inputs();
        tick();
        vecs++;
        if (hif.mem_timeout !== 1'b1 || hif.state !== 2'b00) begin
            $display("FAIL timeout_sticky: got to=%b st=%b want 1/00",
                     hif.mem_timeout, hif.state);
            errs++;
        end
    endtask

    task automatic test_async_reset();
        hif.mem_access = 1'b1;
        hif.sram_ready = 1'b0;
        tick();
        tick();
        vecs++;
        if (hif.state !== 2'b10 || hif.freeze_all !== 1'b1) begin
            $display("FAIL async_pre: got st=%b fa=%b want 10/1",
                     hif.state, hif.freeze_all);
            errs++;
        end
        #1;
        rst = 1'b0;
        #1;
        vecs++;
        if (outs() !== 4'b0000 || hif.state !== 2'b00 ||
            hif.mem_timeout !== 1'b0) begin
            $display("FAIL async_rst: got o=%b st=%b to=%b want 0/00/0",
                     outs(), hif.state, hif.mem_timeout);
            errs++;
        end
        tick();
        clear_inputs();
        #1;
        rst = 1'b1;
        tick();
        vecs++;
        if (hif.state !== 2'b00 || outs() !== 4'b0000) begin
            $display("FAIL async_release: got st=%b o=%b want 00/0000",
                     hif.state, outs());
            errs++;
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst = 1'b0;
        clear_inputs();
        tick();
        test_reset();
        test_load_use();
        test_no_forward();
        test_no_hazard_cases();
        test_branch_hazard();
        test_sram_wait();
        test_wait_branch();
        test_flush_wait();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller for the 5-stage ARM core. It sits beside the forwarding unit and sequences the stall, flush and freeze controls for the IF, ID, EXE and MEM stages. It covers load-use and RAW hazards, SRAM wait states and taken-branch flushes. A small state machine holds the pipeline through multi-cycle memory accesses and suppresses false hazards on bubbles after a flush.

## Interface
Parameters:
- REG_W, 4, register-index width
- WAIT_LIMIT, 255, maximum SRAM wait cycles before timeout flag
- CNT_W, 16, stall-statistics counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- src1, src2  in  REG_W  ID-stage source registers
- two_src  in  1  ID instruction reads src2
- exe_dest  in  REG_W  EXE-stage destination
- exe_wb_en  in  1  EXE-stage writes back
- exe_mem_r_en  in  1  EXE-stage instruction is a load
- mem_dest  in  REG_W  MEM-stage destination
- mem_wb_en  in  1  MEM-stage writes back
- forward_en  in  1  forwarding enabled
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_access  in  1  MEM stage issuing SRAM read or write
- sram_ready  in  1  SRAM access completes this cycle
- freeze_pc  out  1  hold PC and IF/ID register
- flush_if_id  out  1  clear IF/ID
- flush_id_ex  out  1  insert bubble into ID/EX
- freeze_all  out  1  hold IF/ID, ID/EX, EXE/MEM, MEM/WB
- state  out  2  RUN=00, STALL=01, WAIT=10, FLUSH=11
- mem_timeout  out  1  sticky: wait exceeded WAIT_LIMIT
- stall_count  out  CNT_W  stall cycles (HAZARD_STATS_EN only)

## Operation
- raw_exe = exe_wb_en && (exe_dest==src1 || (two_src && exe_dest==src2)).
- raw_mem = the same expression using mem_wb_en and mem_dest.
- hazard = forward_en ? (raw_exe && exe_mem_r_en) : (raw_exe || raw_mem).
- Hazard is forced 0 in FLUSH state, because ID holds a bubble.
- Event priority: wait (mem_access && !sram_ready) > branch_taken > hazard.
- RUN:
  - wait → WAIT.
  - Else branch_taken → FLUSH.
  - Else hazard → STALL.
  - Else stay in RUN.
- STALL:
  - wait → WAIT.
  - branch_taken → FLUSH.
  - hazard still true → STALL (forward_en=0 path; stays until producer reaches WB).
  - Else → RUN.
- WAIT:
  - Stay while !sram_ready.
  - On sram_ready: go to FLUSH if branch_taken, else STALL if hazard, else RUN.
  - Wait counter increments each WAIT cycle and clears on exit.
  - When the counter reaches WAIT_LIMIT, mem_timeout sets and stays set until reset; the state stays WAIT.
- FLUSH: lasts exactly one cycle, then → RUN. If wait is asserted in that cycle → WAIT.
- Outputs are combinational from state and current inputs:
  - freeze_all = wait.
  - freeze_pc = wait || (hazard && !branch_taken).
  - flush_if_id = branch_taken && !wait.
  - flush_id_ex = (hazard || branch_taken) && !wait.
- In WAIT, freeze_all dominates: no flush is issued until the cycle sram_ready is high.
- Reset:
  - State → RUN; wait counter, mem_timeout and stall_count → 0.
  - All outputs are 0 while rst is low, independent of inputs.

## Timing
- Zero-cycle response: stall, flush and freeze assert in the same cycle as the triggering inputs.
- Load-use with forwarding costs exactly 1 bubble cycle.
- Without forwarding, stall lasts until the producer leaves MEM: max 2 cycles.
- SRAM access of N wait cycles: freeze_all high for N cycles, deasserting in the cycle sram_ready=1.
- Reset asserted mid-WAIT: state returns to RUN asynchronously; freeze_all drops immediately.
- src equal to dest with wb_en=0 is not a hazard. Register 0 is not special.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle where freeze_pc or freeze_all is high.
  - It saturates at all-ones and resets to 0.
- HAZARD_STATS_EN undefined:
  - The counter logic is removed and the stall_count port is absent.
  - All other behaviour is identical.

## Test plan
- Load-use, forward_en=1:
  - Stimulus: exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, src1=3 for one cycle.
  - Response: freeze_pc=1 and flush_id_ex=1 for 1 cycle; state RUN→STALL→RUN.
- No forwarding:
  - Stimulus: mem_wb_en=1, mem_dest=5, src2=5, two_src=1, forward_en=0.
  - Response: stall held; with two_src=0 instead, no stall.
- SRAM wait:
  - Stimulus: mem_access=1, sram_ready low for 4 cycles.
  - Response: freeze_all=1 for 4 cycles, state=WAIT. With HAZARD_STATS_EN, stall_count=4.
- Branch during hazard:
  - Stimulus: branch_taken=1 and hazard in the same cycle.
  - Response: flush_if_id=1, flush_id_ex=1, freeze_pc=0. Next cycle state=FLUSH and hazard is ignored.
- Timeout:
  - Stimulus: WAIT_LIMIT=8, sram_ready held 0 for 10 cycles.
  - Response: mem_timeout rises after the 8th wait cycle and stays set after sram_ready.
- Async reset mid-WAIT:
  - Stimulus: rst driven 0 while in WAIT.
  - Response: all outputs 0 immediately; state=RUN after release.
